// File: rtl/rot_ring_pkg.sv
// Shared encodings and the reset pattern for the rotating register ring.
// The optional ROT_RING_MODCNT_EN build only affects rot_ring_ctrl.
package rot_ring_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_FWD  = 2'b01;
  localparam logic [1:0] OP_BWD  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Slot k powers up holding k+1, wrapped to the slot width.
  function automatic int unsigned slot_rst_val(input int unsigned k, input int unsigned width);
    return (k + 1) % (32'd1 << width);
  endfunction

endpackage

// File: rtl/rot_ring_dp.sv
// Slot registers of the ring: load, clear and single-slot forward/backward steps.
// No sequencing lives here; the controller decides which control is active.
module rot_ring_dp
  import rot_ring_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic                   clr_en,
  input  logic                   step_fwd,
  input  logic                   step_bwd,
  input  logic [DEPTH*WIDTH-1:0] load_data,
  output logic [DEPTH*WIDTH-1:0] ring
);

  localparam int RW = DEPTH * WIDTH;

  logic [RW-1:0] ring_q;
  logic [RW-1:0] ring_d;
  logic [RW-1:0] rst_val;
  logic [RW-1:0] fwd_val;
  logic [RW-1:0] bwd_val;

  always_comb begin
    rst_val = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      rst_val[k*WIDTH +: WIDTH] = WIDTH'(slot_rst_val(k, WIDTH));
    end
  end

  // Slot 0 sits in the low bits, so a forward step is a left rotate by one slot.
  assign fwd_val = {ring_q[RW-WIDTH-1:0], ring_q[RW-1 -: WIDTH]};
  assign bwd_val = {ring_q[WIDTH-1:0], ring_q[RW-1:WIDTH]};

  always_comb begin
    ring_d = ring_q;
    if (clr_en) begin
      ring_d = '0;
    end else if (load_en) begin
      ring_d = load_data;
    end else if (step_fwd) begin
      ring_d = fwd_val;
    end else if (step_bwd) begin
      ring_d = bwd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q <= rst_val;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign ring = ring_q;

endmodule

// File: rtl/rot_ring_ctrl.sv
// Command sequencer for a DEPTH-slot rotating ring: handshake, step counter and FSM.
// Define ROT_RING_MODCNT_EN to reduce rotate counts modulo DEPTH at acceptance.
module rot_ring_ctrl
  import rot_ring_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [CNT_W-1:0]       cmd_cnt,
  input  logic [DEPTH*WIDTH-1:0] load_data,
  output logic [DEPTH*WIDTH-1:0] ring_out,
  output logic                   busy,
  output logic                   done
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] remaining_q;
  logic [CNT_W-1:0] remaining_d;
  logic             dir_bwd_q;
  logic             dir_bwd_d;

  logic             accept;
  logic [CNT_W-1:0] eff_cnt;
  logic             load_en;
  logic             clr_en;
  logic             step_fwd;
  logic             step_bwd;

  assign accept = cmd_valid && (state_q == IDLE);

`ifdef ROT_RING_MODCNT_EN
  // Whole revolutions leave the ring unchanged, so only the remainder is stepped.
  assign eff_cnt = CNT_W'(32'(cmd_cnt) % 32'(DEPTH));
`else
  assign eff_cnt = cmd_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      dir_bwd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_bwd_q   <= dir_bwd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_bwd_d   = dir_bwd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_FWD, OP_BWD: begin
              dir_bwd_d = (cmd_op == OP_BWD);
              if (eff_cnt == '0) begin
                state_d = DONE;
              end else begin
                remaining_d = eff_cnt;
                state_d     = ROTATE;
              end
            end
            default: state_d = DONE;
          endcase
        end
      end
      ROTATE: begin
        // The step taken with one remaining is the last; leave with the counter at zero.
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q == ROTATE);
    done      = (state_q == DONE);
    load_en   = accept && (cmd_op == OP_LOAD);
    clr_en    = accept && (cmd_op == OP_CLR);
    step_fwd  = (state_q == ROTATE) && !dir_bwd_q;
    step_bwd  = (state_q == ROTATE) && dir_bwd_q;
  end

  rot_ring_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .clr_en    (clr_en),
    .step_fwd  (step_fwd),
    .step_bwd  (step_bwd),
    .load_data (load_data),
    .ring      (ring_out)
  );

endmodule
